select_output_sync: RTL and testbench

SELECT_OUTPUT_SYNC -- requirements
Module: select_output_sync

---
 rtl/select_output_sync.sv | 243 ++++++++++++++++++++++++
 tb/tb_select_output_sync.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_output_sync.sv
// -----------------------------------------------------------------------------
// select_output_sync
//
// Selects one of N_CH byte-wide transport-stream channels and forwards it to a
// single registered output. A channel change is requested over SPI (or from a
// switch input when USE_SW=1). A change never cuts a packet: the block finishes
// the packet in flight on the old channel (DRAIN), waits for a packet start on
// the new channel (ALIGN), then commits and pulses a downstream reset.
//
// Handshake: a beat on channel k exists only in a cycle where D_VALID_BUS[k]
// is 1. P_SYNC_BUS[k] and DATA_IN[8k+7:8k] are ignored unless that valid bit is
// high. There is no backpressure: each beat is seen once and forwarded (or
// dropped) in the same cycle. On the output side a beat exists only in a cycle
// where D_VALID_OUT is 1. P_SYNC_OUT is 0 whenever D_VALID_OUT is 0, and
// DATA_OUT then keeps the last forwarded byte.
//
// Ports
//   CLK                 clock, all inputs synchronous to it
//   RST                 synchronous active-low reset
//   SPI_ADDRESS[7:0]    last SPI register address
//   SPI_DATA[7:0]       last SPI data byte
//   RISING_SS           one-cycle strobe at the end of an SPI transaction
//   SW[SEL_W-1:0]       switch selection (used only when USE_SW=1)
//   DATA_IN[N_CH*8-1:0] channel bytes, channel k at bits [8k+7:8k]
//   D_VALID_BUS[N_CH-1:0] per-channel byte valid
//   P_SYNC_BUS[N_CH-1:0]  per-channel first-byte-of-packet flag
//   DATA_OUT[7:0]       registered selected byte
//   D_VALID_OUT         registered selected valid
//   P_SYNC_OUT          registered selected packet sync
//   SEL_OUT[SEL_W-1:0]  committed active channel
//   SWITCHING           high while a change is in progress (DRAIN or ALIGN)
//   RESET_ON_CHANGE_OUT downstream reset pulse after a channel commit
//   state_dbg[1:0]      current FSM state (0 RUN, 1 DRAIN, 2 ALIGN)
// -----------------------------------------------------------------------------
module select_output_sync #(
  parameter int         N_CH      = 4,
  parameter int         SEL_W     = 2,
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] ADDR_SEL  = 8'h10,
  parameter bit         USE_SW    = 1'b0,
  parameter int         RST_PULSE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        SPI_ADDRESS,
  input  logic [7:0]        SPI_DATA,
  input  logic              RISING_SS,
  input  logic [SEL_W-1:0]  SW,
  input  logic [N_CH*8-1:0] DATA_IN,
  input  logic [N_CH-1:0]   D_VALID_BUS,
  input  logic [N_CH-1:0]   P_SYNC_BUS,
  output logic [7:0]        DATA_OUT,
  output logic              D_VALID_OUT,
  output logic              P_SYNC_OUT,
  output logic [SEL_W-1:0]  SEL_OUT,
  output logic              SWITCHING,
  output logic              RESET_ON_CHANGE_OUT,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ALIGN = 2'd2
  } state_t;

  localparam logic [7:0] PKT_L  = 8'(PKT_LEN);
  localparam logic [7:0] NCH_L  = 8'(N_CH);
  localparam logic [3:0] PULSE_L = 4'(RST_PULSE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [SEL_W-1:0] active, active_nxt;
  logic [SEL_W-1:0] pend, pend_nxt;
  logic [7:0]       cnt, cnt_nxt, cnt_d;
  logic [3:0]       pulse_cnt, pulse_nxt;
  logic [SEL_W-1:0] sw_last;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             spi_fire;
  logic             sw_fire;
  logic             req_fire;
  logic [7:0]       req_raw;
  logic             req_ok;
  logic [SEL_W-1:0] req_val;
  logic [SEL_W-1:0] pend_eff;

  always_comb begin
    spi_fire = RISING_SS && (SPI_ADDRESS == ADDR_SEL);
    sw_fire  = (SW != sw_last);
    req_fire = USE_SW ? sw_fire : spi_fire;
    // The range check uses the whole byte: 0x05 must be rejected even though
    // its low SEL_W bits would name a real channel.
    req_raw  = USE_SW ? 8'(SW) : SPI_DATA;
    req_ok   = req_fire && (req_raw < NCH_L);
    req_val  = req_raw[SEL_W-1:0];
    // A request arriving this cycle wins over the registered one.
    pend_eff = req_ok ? req_val : pend;
  end

  // ---------------------------------------------------------------------------
  // Channel beat selection
  // ---------------------------------------------------------------------------
  logic       a_valid, a_sync;
  logic [7:0] a_data;
  logic       p_valid, p_sync;
  logic [7:0] p_data;

  always_comb begin
    a_valid = D_VALID_BUS[active];
    a_sync  = a_valid && P_SYNC_BUS[active];
    a_data  = DATA_IN[8*int'(active) +: 8];
    p_valid = D_VALID_BUS[pend_eff];
    p_sync  = p_valid && P_SYNC_BUS[pend_eff];
    p_data  = DATA_IN[8*int'(pend_eff) +: 8];
  end

  // Byte position of the active channel after this cycle's beat. Stays 0
  // until the first sync has been seen, so an unaligned stream reads as 0.
  always_comb begin
    cnt_nxt = cnt;
    if (a_valid) begin
      if (a_sync) begin
        cnt_nxt = 8'd1;
      end else if (cnt != 8'd0) begin
        cnt_nxt = cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and output beat
  // ---------------------------------------------------------------------------
  logic       fwd_valid, fwd_sync;
  logic [7:0] fwd_data;

  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    pend_nxt   = pend;
    cnt_d      = cnt_nxt;
    pulse_nxt  = (pulse_cnt != 4'd0) ? pulse_cnt - 4'd1 : 4'd0;
    fwd_valid  = 1'b0;
    fwd_sync   = 1'b0;
    fwd_data   = DATA_OUT;

    unique case (state)
      ST_RUN: begin
        fwd_valid = a_valid;
        fwd_sync  = a_sync;
        if (a_valid) fwd_data = a_data;
        if (req_ok && (req_val != active)) begin
          pend_nxt = req_val;
          // Judged on the count including this cycle's beat: if that beat
          // closed a packet (or nothing is aligned yet) there is nothing left
          // to drain.
          if ((cnt_nxt == 8'd0) || (cnt_nxt == PKT_L)) begin
            state_nxt = ST_ALIGN;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (req_ok && (req_val == active)) begin
          // Switch cancelled: behave exactly like RUN this cycle, no gap.
          pend_nxt  = req_val;
          state_nxt = ST_RUN;
          fwd_valid = a_valid;
          fwd_sync  = a_sync;
          if (a_valid) fwd_data = a_data;
        end else begin
          if (req_ok) pend_nxt = req_val;
          if (a_sync) begin
            // Short packet: the old channel already started a new packet,
            // which must not leak out. Drop it and go align.
            state_nxt = ST_ALIGN;
          end else begin
            fwd_valid = a_valid;
            if (a_valid) fwd_data = a_data;
            if (cnt_nxt == PKT_L) state_nxt = ST_ALIGN;
          end
        end
      end

      ST_ALIGN: begin
        if (req_ok) pend_nxt = req_val;
        if (p_sync) begin
          active_nxt = pend_eff;
          pend_nxt   = pend_eff;
          cnt_d      = 8'd1;
          pulse_nxt  = PULSE_L;
          fwd_valid  = 1'b1;
          fwd_sync   = 1'b1;
          fwd_data   = p_data;
          state_nxt  = ST_RUN;
        end
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_RUN;
      active      <= '0;
      pend        <= '0;
      cnt         <= '0;
      pulse_cnt   <= '0;
      sw_last     <= SW;
      DATA_OUT    <= '0;
      D_VALID_OUT <= 1'b0;
      P_SYNC_OUT  <= 1'b0;
    end else begin
      state       <= state_nxt;
      active      <= active_nxt;
      pend        <= pend_nxt;
      cnt         <= cnt_d;
      pulse_cnt   <= pulse_nxt;
      sw_last     <= SW;
      DATA_OUT    <= fwd_data;
      D_VALID_OUT <= fwd_valid;
      P_SYNC_OUT  <= fwd_sync;
    end
  end

  assign SEL_OUT             = active;
  assign SWITCHING           = (state != ST_RUN);
  assign RESET_ON_CHANGE_OUT = (pulse_cnt != 4'd0);
  assign state_dbg           = state;

endmodule

// File: tb/tb_select_output_sync.sv
// -----------------------------------------------------------------------------
// tb_select_output_sync
//
// Directed bench for select_output_sync with default parameters (4 channels,
// 188-byte packets, SPI select at 0x10, 4-cycle downstream reset pulse).
// Four free-running packet streams with random valid gaps feed the block.
// Every beat the bench expects to see at the output is pushed to exp_q when
// it is driven and popped one cycle later when the output is sampled.
// -----------------------------------------------------------------------------
module tb_select_output_sync;

  localparam int NCH = 4;
  localparam int PLEN = 188;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK;
  logic RST;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [7:0]       SPI_ADDRESS;
  logic [7:0]       SPI_DATA;
  logic             RISING_SS;
  logic [1:0]       SW;
  logic [NCH*8-1:0] DATA_IN;
  logic [NCH-1:0]   D_VALID_BUS;
  logic [NCH-1:0]   P_SYNC_BUS;
  logic [7:0]       DATA_OUT;
  logic             D_VALID_OUT;
  logic             P_SYNC_OUT;
  logic [1:0]       SEL_OUT;
  logic             SWITCHING;
  logic             RESET_ON_CHANGE_OUT;
  logic [1:0]       state_dbg;

  select_output_sync dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .SPI_ADDRESS         (SPI_ADDRESS),
    .SPI_DATA            (SPI_DATA),
    .RISING_SS           (RISING_SS),
    .SW                  (SW),
    .DATA_IN             (DATA_IN),
    .D_VALID_BUS         (D_VALID_BUS),
    .P_SYNC_BUS          (P_SYNC_BUS),
    .DATA_OUT            (DATA_OUT),
    .D_VALID_OUT         (D_VALID_OUT),
    .P_SYNC_OUT          (P_SYNC_OUT),
    .SEL_OUT             (SEL_OUT),
    .SWITCHING           (SWITCHING),
    .RESET_ON_CHANGE_OUT (RESET_ON_CHANGE_OUT),
    .state_dbg           (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];
  logic [7:0] last_data;
  int         errors;
  int         checks;

  // Stream generator state
  int         nxt_pos[NCH];
  int         cur_pos[NCH];
  logic [NCH-1:0] cur_valid;
  logic [NCH-1:0] cur_sync;
  logic [7:0] cur_data[NCH];
  logic [NCH-1:0] stall;

  function automatic logic [7:0] byte_of(input int k, input int p);
    if (p == 1) return 8'h47;
    return 8'((k * 37 + p * 3) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Decide this cycle's beat on every channel. Invalid cycles carry junk data
  // and junk sync flags, which the block must ignore.
  task automatic gen();
    for (int k = 0; k < NCH; k++) begin
      cur_pos[k]   = nxt_pos[k];
      cur_valid[k] = !stall[k] && ($urandom_range(0, 3) != 0);
      if (cur_valid[k]) begin
        cur_sync[k] = (nxt_pos[k] == 1);
        cur_data[k] = byte_of(k, nxt_pos[k]);
        nxt_pos[k]  = (nxt_pos[k] == PLEN) ? 1 : nxt_pos[k] + 1;
      end else begin
        cur_sync[k] = 1'($urandom_range(0, 1));
        cur_data[k] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
    SPI_ADDRESS = addr;
    SPI_DATA    = data;
    RISING_SS   = 1'b1;
  endtask

  // Apply the beats from gen(), expect channel exp_ch (or nothing when -1)
  // at the output one cycle later, and score the output.
  task automatic step(input int exp_ch);
    logic [8:0] e;
    bit has_exp;
    for (int k = 0; k < NCH; k++) begin
      D_VALID_BUS[k]     = cur_valid[k];
      P_SYNC_BUS[k]      = cur_sync[k];
      DATA_IN[8*k +: 8]  = cur_data[k];
    end
    if (exp_ch >= 0 && cur_valid[exp_ch]) exp_q.push_back({cur_sync[exp_ch], cur_data[exp_ch]});
    @(posedge CLK);
    #1;
    RISING_SS = 1'b0;
    has_exp = (exp_q.size() != 0);
    check("valid_out", D_VALID_OUT, has_exp);
    if (has_exp) begin
      e = exp_q.pop_front();
      if (D_VALID_OUT === 1'b1) check("beat", {P_SYNC_OUT, DATA_OUT}, e);
      last_data = e[7:0];
    end else if (D_VALID_OUT !== 1'b1) begin
      check("hold_data", {P_SYNC_OUT, DATA_OUT}, {1'b0, last_data});
    end
  endtask

  task automatic run(input int n, input int exp_ch);
    for (int i = 0; i < n; i++) begin
      gen();
      step(exp_ch);
    end
  endtask

  // Run forwarding exp_ch until channel ch is about to present byte p; the
  // matching beat is left generated but not yet driven.
  task automatic run_until_pos(input int ch, input int p, input int exp_ch,
                               input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      gen();
      if (cur_valid[ch] && cur_pos[ch] == p) found = 1'b1;
      else step(exp_ch);
    end
    check({tag, "_found_pos"}, found, 1);
  endtask

  // Old channel ch keeps flowing until its byte PLEN is out.
  task automatic drain(input int ch, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      gen();
      done = cur_valid[ch] && (cur_pos[ch] == PLEN);
      step(ch);
      check({tag, "_switching"}, SWITCHING, 1);
    end
    check({tag, "_drain_done"}, done, 1);
  endtask

  // Nothing comes out until channel ch starts a packet; that beat commits.
  task automatic wait_commit(input int ch, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      gen();
      if (cur_valid[ch] && cur_sync[ch]) begin
        done = 1'b1;
        step(ch);
      end else begin
        step(-1);
        check({tag, "_align_switching"}, SWITCHING, 1);
      end
    end
    check({tag, "_commit_seen"}, done, 1);
  endtask

  task automatic check_pulse(input int ch, input int sel, input string tag);
    check({tag, "_sel"}, SEL_OUT, sel);
    check({tag, "_switching_off"}, SWITCHING, 0);
    check({tag, "_pulse_c1"}, RESET_ON_CHANGE_OUT, 1);
    for (int i = 1; i <= 4; i++) begin
      gen();
      step(ch);
      check({tag, "_pulse_tail"}, RESET_ON_CHANGE_OUT, (i < 4) ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, D_VALID_OUT, 0);
    check({tag, "_sync"}, P_SYNC_OUT, 0);
    check({tag, "_data"}, DATA_OUT, 0);
    check({tag, "_sel"}, SEL_OUT, 0);
    check({tag, "_switching"}, SWITCHING, 0);
    check({tag, "_pulse"}, RESET_ON_CHANGE_OUT, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ch3_seen;
    bit done;
    errors = 0;
    checks = 0;
    last_data = 8'h00;
    RST = 1'b0;
    SPI_ADDRESS = 8'h00;
    SPI_DATA = 8'h00;
    RISING_SS = 1'b0;
    SW = 2'b00;
    DATA_IN = '0;
    D_VALID_BUS = '0;
    P_SYNC_BUS = '0;
    nxt_pos[0] = 1;
    nxt_pos[1] = 100;
    nxt_pos[2] = 30;
    nxt_pos[3] = 150;
    stall = 4'hF;

    // Reset state
    run(3, -1);
    check_reset_outputs("reset");
    RST = 1'b1;
    stall = 4'h0;

    // ch0 packets pass through one cycle late
    run(420, 0);
    check("t1_sel", SEL_OUT, 0);
    check("t1_switching", SWITCHING, 0);

    // Out-of-range value and wrong address do nothing
    gen();
    spi_write(8'h10, 8'h05);
    step(0);
    check("t5_range_switching", SWITCHING, 0);
    gen();
    spi_write(8'h11, 8'h02);
    step(0);
    check("t5_addr_switching", SWITCHING, 0);
    for (int i = 0; i < 30; i++) begin
      gen();
      step(0);
      check("t5_idle_switching", SWITCHING, 0);
    end
    check("t5_sel", SEL_OUT, 0);

    // Write 0x02 then 0x00 while draining: cancelled, no gap, no pulse
    run_until_pos(0, 20, 0, "t3");
    spi_write(8'h10, 8'h02);
    step(0);
    check("t3_drain_entered", SWITCHING, 1);
    run(5, 0);
    gen();
    spi_write(8'h10, 8'h00);
    step(0);
    check("t3_cancel_switching", SWITCHING, 0);
    check("t3_cancel_sel", SEL_OUT, 0);
    for (int i = 0; i < 250; i++) begin
      gen();
      step(0);
      check("t3_no_pulse", RESET_ON_CHANGE_OUT, 0);
    end
    check("t3_sel", SEL_OUT, 0);

    // Switch to ch2 at ch0 byte 50
    run_until_pos(0, 50, 0, "t2");
    spi_write(8'h10, 8'h02);
    step(0);
    drain(0, "t2");
    wait_commit(2, "t2");
    check_pulse(2, 2, "t2");
    run(60, 2);
    check("t2_sel_after", SEL_OUT, 2);

    // Request 3, then 1 during ALIGN: ch3 sync ignored, commit on ch1
    run_until_pos(2, 10, 2, "t4");
    spi_write(8'h10, 8'h03);
    step(2);
    drain(2, "t4");
    stall[1] = 1'b1;
    gen();
    spi_write(8'h10, 8'h01);
    ch3_seen = cur_valid[3] && cur_sync[3];
    step(-1);
    for (int n = 0; n < 3000 && !ch3_seen; n++) begin
      gen();
      ch3_seen = cur_valid[3] && cur_sync[3];
      step(-1);
      check("t4_align_switching", SWITCHING, 1);
    end
    check("t4_ch3_sync_seen", ch3_seen, 1);
    check("t4_sel_held", SEL_OUT, 2);
    stall[1] = 1'b0;
    wait_commit(1, "t4");
    check_pulse(1, 1, "t4");
    run(60, 1);

    // Reset in the middle of ALIGN abandons the switch
    run_until_pos(1, 180, 1, "t6");
    spi_write(8'h10, 8'h00);
    step(1);
    drain(1, "t6");
    stall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gen();
      step(-1);
      check("t6_align_switching", SWITCHING, 1);
    end
    RST = 1'b0;
    last_data = 8'h00;
    gen();
    step(-1);
    check_reset_outputs("t6_reset");
    RST = 1'b1;
    stall[0] = 1'b0;
    done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gen();
      step(0);
      if (RESET_ON_CHANGE_OUT !== 1'b0) done = 1'b0;
    end
    check("t6_no_pulse_after_reset", done, 1);
    check("t6_sel", SEL_OUT, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop in case a loop bound is ever misjudged.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
